// File: rtl/fitbit_pkg.sv
// Shared definitions for the fitness-tracker display scheduler.
//   page_t        : display page encodings (STEPS / DISTANCE / MODE)
//   conv_state_t  : binary-to-BCD request sequencer states
//   BCD_OFLOW     : digits shown when the step counter has overflowed
//   DOT_MASK      : decimal-point enable indexed by page
//   next_page()   : page rotation order
//   dist_bcd()    : half-unit distance to two BCD digits (x.0 / x.5)
package fitbit_pkg;

    typedef enum logic [1:0] {
        PG_STEPS = 2'd0,
        PG_DIST  = 2'd1,
        PG_MODE  = 2'd2
    } page_t;

    typedef enum logic [1:0] {
        CS_IDLE = 2'd0,
        CS_REQ  = 2'd1,
        CS_WAIT = 2'd2
    } conv_state_t;

    localparam logic [15:0] BCD_OFLOW = 16'h9999;

    // Bit n set = decimal point lit on page n; only DISTANCE has one.
    localparam logic [3:0] DOT_MASK = 4'b0010;

    function automatic page_t next_page(input page_t p);
        case (p)
            PG_STEPS: next_page = PG_DIST;
            PG_DIST:  next_page = PG_MODE;
            default:  next_page = PG_STEPS;
        endcase
    endfunction

    // Integer part saturates at 9 so the digit stays a legal BCD code.
    function automatic logic [15:0] dist_bcd(input logic [4:0] d);
        logic [3:0] whole;
        whole    = (d[4:1] > 4'd9) ? 4'd9 : d[4:1];
        dist_bcd = {8'h00, whole, d[0] ? 4'd5 : 4'd0};
    endfunction

endpackage

// File: rtl/fitbit_conv_seq.sv
// Binary-to-BCD converter request sequencer.
// Waits REFRESH_CYCLES in IDLE, issues a one-cycle conv_start with the
// step count latched on conv_bin, then waits up to TIMEOUT_CYCLES for
// conv_done. A result is kept in steps_bcd; a timeout pulses conv_err and
// leaves the previous result in place.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   steps        binary step count to convert
//   conv_done    converter completion strobe (only honoured in WAIT)
//   conv_bcd     converter result, valid with conv_done
//   conv_start   one-cycle request (high while in REQ)
//   conv_bin     operand, stable from conv_start until done/abort
//   conv_err     one-cycle pulse on timeout
//   steps_bcd    last successfully converted step count
module fitbit_conv_seq
    import fitbit_pkg::*;
#(
    parameter int REFRESH_CYCLES = 64,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] steps,
    input  logic        conv_done,
    input  logic [15:0] conv_bcd,
    output logic        conv_start,
    output logic [13:0] conv_bin,
    output logic        conv_err,
    output logic [15:0] steps_bcd
);

    localparam int REF_W = $clog2(REFRESH_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    conv_state_t      state;
    logic [REF_W-1:0] ref_cnt;
    logic [TO_W-1:0]  to_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= CS_IDLE;
            ref_cnt    <= '0;
            to_cnt     <= '0;
            conv_start <= 1'b0;
            conv_bin   <= '0;
            conv_err   <= 1'b0;
            steps_bcd  <= '0;
        end else begin
            conv_start <= 1'b0;
            conv_err   <= 1'b0;
            case (state)
                CS_IDLE: begin
                    if (ref_cnt == REF_W'(REFRESH_CYCLES - 1)) begin
                        // Registered outputs: start and operand appear
                        // together in the REQ cycle.
                        state      <= CS_REQ;
                        conv_start <= 1'b1;
                        conv_bin   <= steps;
                        ref_cnt    <= '0;
                    end else begin
                        ref_cnt <= ref_cnt + REF_W'(1);
                    end
                end
                CS_REQ: begin
                    state  <= CS_WAIT;
                    to_cnt <= '0;
                end
                CS_WAIT: begin
                    // Done is tested first so it wins over a simultaneous timeout.
                    if (conv_done) begin
                        steps_bcd <= conv_bcd;
                        state     <= CS_IDLE;
                        ref_cnt   <= '0;
                    end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        conv_err <= 1'b1;
                        state    <= CS_IDLE;
                        ref_cnt  <= '0;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                default: begin
                    state   <= CS_IDLE;
                    ref_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/fitbit_display_sched.sv
// Display scheduler: rotates the 4-digit display through STEPS, DISTANCE
// and MODE pages, runs the converter sequencer, and registers the BCD word
// and decimal point for the segment driver.
// Ports:
//   CLK, RST_N           clock, synchronous active-low reset
//   MODE, STEPS,
//   DISTANCE, OFLOW      data sources from the step tracker
//   HOLD                 1 = freeze page rotation
//   CONV_START/CONV_BIN  request + operand to binary-to-BCD converter
//   CONV_DONE/CONV_BCD   converter completion + result
//   BCD, DOT             registered digits and decimal point
//   PAGE                 current page (0=STEPS 1=DISTANCE 2=MODE)
//   CONV_ERR             one-cycle converter timeout pulse
module fitbit_display_sched
    import fitbit_pkg::*;
#(
    parameter int DWELL_CYCLES   = 200000000,
    parameter int REFRESH_CYCLES = 64,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [1:0]  MODE,
    input  logic [13:0] STEPS,
    input  logic [4:0]  DISTANCE,
    input  logic        OFLOW,
    input  logic        HOLD,
    output logic        CONV_START,
    output logic [13:0] CONV_BIN,
    input  logic        CONV_DONE,
    input  logic [15:0] CONV_BCD,
    output logic [15:0] BCD,
    output logic        DOT,
    output logic [1:0]  PAGE,
    output logic        CONV_ERR
);

    localparam int DW_W = $clog2(DWELL_CYCLES);

    page_t           page;
    logic [DW_W-1:0] dwell_cnt;
    logic [15:0]     steps_bcd;

    fitbit_conv_seq #(
        .REFRESH_CYCLES(REFRESH_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_conv_seq (
        .clk       (CLK),
        .rst_n     (RST_N),
        .steps     (STEPS),
        .conv_done (CONV_DONE),
        .conv_bcd  (CONV_BCD),
        .conv_start(CONV_START),
        .conv_bin  (CONV_BIN),
        .conv_err  (CONV_ERR),
        .steps_bcd (steps_bcd)
    );

    // Page rotation; HOLD simply stalls the dwell counter so release
    // resumes from the held count.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            page      <= PG_STEPS;
            dwell_cnt <= '0;
        end else if (!HOLD) begin
            if (dwell_cnt == DW_W'(DWELL_CYCLES - 1)) begin
                dwell_cnt <= '0;
                page      <= next_page(page);
            end else begin
                dwell_cnt <= dwell_cnt + DW_W'(1);
            end
        end
    end

    assign PAGE = page;

    // Output registers follow the page/source with one cycle of latency.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            BCD <= '0;
            DOT <= 1'b0;
        end else begin
            DOT <= DOT_MASK[page];
            case (page)
                PG_STEPS: BCD <= OFLOW ? BCD_OFLOW : steps_bcd;
                PG_DIST:  BCD <= dist_bcd(DISTANCE);
                PG_MODE:  BCD <= {14'b0, MODE};
                default:  BCD <= '0;
            endcase
        end
    end

endmodule
